// File: rtl/marquee_pkg.sv
// Shared encodings for the marquee scroll controller: FSM states and scroll modes.
package marquee_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_WRAP_L = 2'd0,
    MODE_WRAP_R = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_t;

  // The reserved code 11 behaves like wrap-left.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_WRAP_R;
      2'b10:   return MODE_BOUNCE;
      default: return MODE_WRAP_L;
    endcase
  endfunction

endpackage

// File: rtl/marquee_ctrl_tick_gen.sv
// Scroll-tick prescaler: counts 0..DIV-1 while run is high, flags the last count.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt;
  logic         last;

  assign last = (cnt == W'(DIV - 1));
  assign tick = run && last;

  // Free-running divider; held at zero whenever the controller is idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (run)    cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/marquee_ctrl.sv
// Marquee scroll controller: paces a digit-shift datapath in wrap-left,
// wrap-right or bounce mode. Define MARQUEE_CTRL_PAUSE_EN to hold PAUSE_TICKS
// ticks at each bounce end; otherwise bounce reverses without stopping.
module marquee_ctrl
  import marquee_pkg::*;
#(
  parameter int N           = 32,
  parameter int WIDTH       = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int PAUSE_TICKS = 2
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [1:0]                     mode,
  output logic                           step_en,
  output logic                           dir,
  output logic [$clog2(N/WIDTH)-1:0]     pos,
  output logic                           busy,
  output logic [1:0]                     state
);

  localparam int STEPS = N / WIDTH;
  localparam int PW    = $clog2(STEPS);
  localparam int CW    = $clog2(PAUSE_TICKS + 1);

  state_t         st_q, st_n;
  mode_t          mode_q, mode_n;
  logic [PW-1:0]  pos_n, pos_adv;
  logic [CW-1:0]  pcnt_q, pcnt_n;
  logic           dir_n, step_n, at_end;
  logic           tick, clr, run;

  assign run   = (st_q != ST_IDLE);
  assign clr   = (st_q == ST_IDLE);
  assign state = st_q;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (clr),
    .run       (run),
    .tick      (tick)
  );

  // Next position with wraparound; at_end marks the bounce turn-around point.
  always_comb begin
    pos_adv = pos;
    if (!dir) pos_adv = (pos == PW'(STEPS - 1)) ? '0 : pos + 1'b1;
    else      pos_adv = (pos == '0) ? PW'(STEPS - 1) : pos - 1'b1;
    at_end  = dir ? (pos_adv == '0) : (pos_adv == PW'(STEPS - 1));
  end

  // FSM next-state and next registered-output values.
  always_comb begin
    st_n   = st_q;
    mode_n = mode_q;
    pos_n  = pos;
    dir_n  = dir;
    step_n = 1'b0;
    pcnt_n = pcnt_q;
    case (st_q)
      ST_IDLE: begin
        if (start && !stop) begin
          st_n   = ST_RUN;
          mode_n = decode_mode(mode);
          pos_n  = '0;
          dir_n  = (decode_mode(mode) == MODE_WRAP_R);
          pcnt_n = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          st_n = ST_IDLE;
        end else if (tick) begin
          step_n = 1'b1;
          pos_n  = pos_adv;
          if (mode_q == MODE_BOUNCE && at_end) begin
            dir_n = ~dir;
`ifdef MARQUEE_CTRL_PAUSE_EN
            st_n   = ST_PAUSE;
            pcnt_n = '0;
`else
            st_n   = ST_RUN;
`endif
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          st_n = ST_IDLE;
        end else if (tick) begin
          if (pcnt_q == CW'(PAUSE_TICKS - 1)) begin
            st_n   = ST_RUN;
            pcnt_n = '0;
          end else begin
            pcnt_n = pcnt_q + 1'b1;
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q    <= ST_IDLE;
      mode_q  <= MODE_WRAP_L;
      pos     <= '0;
      dir     <= 1'b0;
      step_en <= 1'b0;
      busy    <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      st_q    <= st_n;
      mode_q  <= mode_n;
      pos     <= pos_n;
      dir     <= dir_n;
      step_en <= step_n;
      busy    <= (st_n != ST_IDLE);
      pcnt_q  <= pcnt_n;
    end
  end

endmodule

// File: tb/tb_marquee_ctrl.sv
// Directed bench for marquee_ctrl (N=32, WIDTH=4, TICK_DIV=4, PAUSE_TICKS=2).
module tb_marquee_ctrl;

  logic       sys_clk, sys_rst_n, start, stop;
  logic [1:0] mode;
  logic       step_en, dir, busy;
  logic [2:0] pos;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  marquee_ctrl #(.N(32), .WIDTH(4), .TICK_DIV(4), .PAUSE_TICKS(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .step_en   (step_en),
    .dir       (dir),
    .pos       (pos),
    .busy      (busy),
    .state     (state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic cyc;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Three quiet cycles, then a step pulse landing on position p with direction d.
  task automatic step_to(input int p, input int d, input int s);
    repeat (3) begin
      cyc;
      chk("gap_step_en", 32'(step_en), 0);
      chk("gap_state", 32'(state), 1);
    end
    cyc;
    chk("step_en", 32'(step_en), 1);
    chk("step_pos", 32'(pos), 32'(p));
    chk("step_dir", 32'(dir), 32'(d));
    chk("step_state", 32'(state), 32'(s));
  endtask

  task automatic do_start(input logic [1:0] m, input int exp_dir);
    mode  = m;
    start = 1'b1;
    cyc;
    start = 1'b0;
    chk("start_state", 32'(state), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_pos", 32'(pos), 0);
    chk("start_dir", 32'(dir), 32'(exp_dir));
    chk("start_step_en", 32'(step_en), 0);
  endtask

  task automatic do_stop;
    stop = 1'b1;
    cyc;
    stop = 1'b0;
    chk("stop_state", 32'(state), 0);
    chk("stop_busy", 32'(busy), 0);
  endtask

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
    cyc; cyc;
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_step_en", 32'(step_en), 0);
    sys_rst_n = 1'b1;
    cyc;

    // Wrap-left; mode input changes mid-run must be ignored.
    do_start(2'b00, 0);
    mode = 2'b01;
    for (int k = 1; k <= 8; k++) step_to(k % 8, 0, 1);
    do_stop;
    chk("stop_pos_hold", 32'(pos), 0);

    // Wrap-right.
    do_start(2'b01, 1);
    for (int k = 7; k >= 0; k--) step_to(k, 1, 1);
    do_stop;

    // Bounce.
    do_start(2'b10, 0);
    for (int k = 1; k <= 6; k++) step_to(k, 0, 1);
`ifdef MARQUEE_CTRL_PAUSE_EN
    step_to(7, 1, 2);
    repeat (7) begin
      cyc;
      chk("pause_state", 32'(state), 2);
      chk("pause_step_en", 32'(step_en), 0);
    end
    cyc;
    chk("pause_exit_state", 32'(state), 1);
    chk("pause_exit_step_en", 32'(step_en), 0);
`else
    step_to(7, 1, 1);
`endif
    for (int k = 6; k >= 1; k--) step_to(k, 1, 1);
`ifdef MARQUEE_CTRL_PAUSE_EN
    step_to(0, 0, 2);
`else
    step_to(0, 0, 1);
    step_to(1, 0, 1);
`endif
    do_stop;

    // Stop on the tick cycle at pos 3 beats the step.
    do_start(2'b00, 0);
    for (int k = 1; k <= 3; k++) step_to(k, 0, 1);
    repeat (3) cyc;
    stop = 1'b1;
    cyc;
    stop = 1'b0;
    chk("tickstop_state", 32'(state), 0);
    chk("tickstop_step_en", 32'(step_en), 0);
    chk("tickstop_pos", 32'(pos), 3);
    chk("tickstop_busy", 32'(busy), 0);
    start = 1'b1; stop = 1'b1;
    cyc;
    start = 1'b0; stop = 1'b0;
    chk("startstop_state", 32'(state), 0);
    chk("startstop_busy", 32'(busy), 0);

    // Asynchronous reset mid-run at pos 5.
    do_start(2'b00, 0);
    for (int k = 1; k <= 5; k++) step_to(k, 0, 1);
    cyc;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pos", 32'(pos), 0);
    chk("arst_dir", 32'(dir), 0);
    chk("arst_step_en", 32'(step_en), 0);
    cyc; cyc;
    sys_rst_n = 1'b1;
    repeat (10) begin
      cyc;
      chk("post_rst_step_en", 32'(step_en), 0);
      chk("post_rst_state", 32'(state), 0);
    end

    // Reserved mode 11 behaves as wrap-left.
    do_start(2'b11, 0);
    step_to(1, 0, 1);
    do_stop;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/marquee_ctrl.md
MARQUEE_CTRL -- requirements
Module: marquee_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, marquee pattern width in bits.
REQ-002 SHALL have parameter WIDTH, default 4, bits per digit; STEPS = N/WIDTH (default 8).
REQ-003 SHALL have parameter TICK_DIV, default 50_000_000, sys_clk cycles per scroll tick (>=2).
REQ-004 SHALL have parameter PAUSE_TICKS, default 2, ticks held at each bounce end (>=1).
REQ-005 SHALL have port sys_clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, level sampled each cycle; begins a scroll run from IDLE.
REQ-008 SHALL have port stop, input, 1, level sampled each cycle; ends the run.
REQ-009 SHALL have port mode, input, 2, 00 wrap-left, 01 wrap-right, 10 bounce, 11 treated as 00.
REQ-010 SHALL have port step_en, output, 1, one-cycle pulse commanding the shift datapath to advance one digit.
REQ-011 SHALL have port dir, output, 1, 0 left (pos increments), 1 right (pos decrements).
REQ-012 SHALL have port pos, output, $clog2(STEPS), current digit offset.
REQ-013 SHALL have port busy, output, 1, high in RUN or PAUSE.
REQ-014 SHALL have port state, output, 2, IDLE=0, RUN=1, PAUSE=2.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE; step_en, dir, pos, busy and state SHALL be registered outputs.
REQ-016 IDLE with start=1 and stop=0 SHALL go to RUN next edge, latch mode, clear prescaler, clear pos to 0, set dir=1 for mode 01, else dir=0.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 only in RUN/PAUSE; tick asserted when count = TICK_DIV-1, count then wraps to 0; first tick occurs TICK_DIV cycles after entering RUN.
REQ-018 RUN on tick SHALL pulse step_en for exactly one cycle (the cycle after the tick edge) and update pos on that edge.
REQ-019 pos SHALL wrap STEPS-1 -> 0 when dir=0 and 0 -> STEPS-1 when dir=1 in wrap modes.
REQ-020 Bounce mode: after a step making pos = STEPS-1 with dir=0, or pos = 0 with dir=1, dir SHALL toggle on the same edge.
REQ-021 stop=1 in RUN/PAUSE SHALL enter IDLE next edge with priority over tick; step_en SHALL be 0 that cycle; pos and dir SHALL hold.
REQ-022 start while busy SHALL be ignored; start and stop together in IDLE SHALL keep IDLE.
REQ-023 mode changes while busy SHALL have no effect until the next start.
REQ-024 step_en SHALL never be asserted in IDLE or PAUSE.

Reset
REQ-025 sys_rst_n low SHALL immediately force state=IDLE, step_en=0, dir=0, pos=0, busy=0, prescaler=0, pause counter=0, latched mode=00.
REQ-026 Reset asserted mid-run SHALL abandon the run; operation resumes only on a new start after release.

Configuration
REQ-027 With MARQUEE_CTRL_PAUSE_EN defined, each bounce direction toggle SHALL also enter PAUSE, hold PAUSE_TICKS ticks without step_en, then return to RUN on the final tick edge.
REQ-028 Without MARQUEE_CTRL_PAUSE_EN, PAUSE SHALL be unreachable and bounce SHALL step continuously; state encoding unchanged.

Structure
REQ-029 Shared package marquee_pkg SHALL hold the state encodings (IDLE/RUN/PAUSE) and mode encodings (wrap-left/wrap-right/bounce).
REQ-030 Prescaler SHALL be a sub-module tick_gen (parameter DIV, inputs sys_clk, sys_rst_n, clr, run; output tick).

Verification (N=32, WIDTH=4, TICK_DIV=4, PAUSE_TICKS=2)
REQ-031 mode=00, start pulse -> busy at next edge; step_en pulses every 4 cycles; pos 0,1,...,7,0; dir=0 throughout.
REQ-032 mode=01, start -> pos 0,7,6,...,1,0; dir=1 throughout.
REQ-033 mode=10 with PAUSE_EN -> pos 1..7, dir toggles to 1 at pos=7, state=PAUSE for 8 cycles, no step_en, then pos 6..0, dir toggles to 0, pause again.
REQ-034 mode=10 without PAUSE_EN -> pos 6 follows 7 exactly 4 cycles later; state never 2.
REQ-035 stop asserted on the tick cycle at pos=3 -> no step_en, IDLE next edge, pos=3 held; start+stop together in IDLE -> stays IDLE.
REQ-036 sys_rst_n pulsed low mid-RUN at pos=5 -> all outputs 0 asynchronously; no step_en after release until a new start.
